// File: rtl/mod_n_cascade.sv
// Cascade of DIGITS modulo-N digit counters with a single-cycle ripple carry/borrow,
// parallel load with per-digit clamping, and wrap or saturate behaviour at the range ends.
module mod_n_cascade #(
  parameter int N      = 10,
  parameter int DIGITS = 4,
  parameter int WIDTH  = $clog2(N),
  parameter int WRAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_val,
  output logic [DIGITS*WIDTH-1:0]   q,
  output logic                      tc,
  output logic                      ovf,
  output logic                      sat
);

  localparam logic [WIDTH-1:0] DMAX = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] DMIN = '0;

  // Declaration initialisers give power-up values equal to the reset values.
  logic [DIGITS*WIDTH-1:0] q_q = '0;
  logic                    ovf_q = 1'b0;
  logic                    sat_q = 1'b0;
  logic [DIGITS*WIDTH-1:0] q_d;
  logic                    ovf_d;
  logic                    sat_d;

  logic [DIGITS-1:0]       is_max;
  logic [DIGITS-1:0]       is_min;
  logic [DIGITS-1:0]       step_en;
  logic [DIGITS*WIDTH-1:0] ld_val;
  logic [DIGITS*WIDTH-1:0] step_val;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] fld;

    assign cur       = q_q[g*WIDTH +: WIDTH];
    assign fld       = load_val[g*WIDTH +: WIDTH];
    assign is_max[g] = (cur == DMAX);
    assign is_min[g] = (cur == DMIN);

    // A digit moves only when every lower digit sits at the end it is leaving.
    if (g == 0) begin : g_lsd
      assign step_en[g] = 1'b1;
    end else begin : g_upper
      assign step_en[g] = up ? &is_max[g-1:0] : &is_min[g-1:0];
    end

    assign ld_val[g*WIDTH +: WIDTH] = (fld > DMAX) ? DMAX : fld;

    assign step_val[g*WIDTH +: WIDTH] =
        !step_en[g] ? cur :
        up          ? (is_max[g] ? DMIN : cur + 1'b1) :
                      (is_min[g] ? DMAX : cur - 1'b1);
  end

  assign tc = ce & (up ? &is_max : &is_min);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    q_d   = q_q;
    ovf_d = 1'b0;
    sat_d = sat_q;
    if (load) begin
      q_d   = ld_val;
      sat_d = 1'b0;
    end else if (ce) begin
      if (tc && (WRAP == 0)) begin
        sat_d = 1'b1;
      end else begin
        // Natural ripple of all-max (or all-zero) already yields the wrapped value.
        q_d   = step_val;
        ovf_d = tc;
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      sat_q <= sat_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign sat = sat_q;

endmodule

// File: doc/mod_n_cascade.md
MOD_N_CASCADE -- requirements
Module: mod_n_cascade

Interface
REQ-001 The module SHALL have parameter N, default 10, meaning the modulus of each digit; legal range N >= 2.
REQ-002 The module SHALL have parameter DIGITS, default 4, meaning the number of cascaded digits; legal range DIGITS >= 1.
REQ-003 The module SHALL have parameter WIDTH, default $clog2(N), meaning the bit width of one digit.
REQ-004 The module SHALL have parameter WRAP, default 1, meaning 1 = wrap at the ends of the range and 0 = saturate at the ends of the range.
REQ-005 The module SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The module SHALL have port ce, input, 1 bit: count enable.
REQ-008 The module SHALL have port up, input, 1 bit: direction, 1 = increment, 0 = decrement.
REQ-009 The module SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-010 The module SHALL have port load_val, input, DIGITS*WIDTH bits: load value; digit i occupies bits [i*WIDTH +: WIDTH]; digit 0 is least significant.
REQ-011 The module SHALL have port q, output, DIGITS*WIDTH bits: registered count, packed the same way as load_val.
REQ-012 The module SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-013 The module SHALL have port ovf, output, 1 bit: registered one-cycle wrap pulse.
REQ-014 The module SHALL have port sat, output, 1 bit: registered saturation flag.

Function
REQ-015 Each clock edge SHALL apply priority rst > load > ce; with none of these active, all registers hold.
REQ-016 On load, each digit SHALL take its load_val field; any field >= N SHALL be clamped to N-1; ovf and sat SHALL be cleared.
REQ-017 On ce with up=1, digit 0 SHALL increment; digit i > 0 SHALL increment only when all lower digits equal N-1; any digit that equals N-1 and is incremented SHALL become 0.
REQ-018 On ce with up=0, digit 0 SHALL decrement; digit i > 0 SHALL decrement only when all lower digits equal 0; any digit that equals 0 and is decremented SHALL become N-1.
REQ-019 The carry/borrow SHALL ripple through all DIGITS within one cycle, so the count advances by exactly one step per enabled cycle.
REQ-020 tc SHALL equal ce AND (up ? all digits = N-1 : all digits = 0).
REQ-021 When WRAP=1 and tc=1, the whole count SHALL wrap: up gives all 0, down gives all N-1; ovf SHALL be 1 in the next cycle only.
REQ-022 When WRAP=0 and tc=1, q SHALL hold; sat SHALL be 1 in the next cycle; ovf SHALL stay 0.
REQ-023 sat SHALL stay 1 until load, rst, or an enabled step away from the end of the range.
REQ-024 A change of up SHALL take effect in the same cycle it is applied; there SHALL be no turnaround latency.
REQ-025 ce asserted together with load SHALL be ignored for that cycle.
REQ-026 q SHALL never hold a digit >= N.

Reset
REQ-027 On rst=1 at a clock edge, q, ovf and sat SHALL all become 0, regardless of load, ce or the current count.
REQ-028 Reset asserted in the cycle of a wrap or saturation event SHALL suppress that cycle's ovf and sat.
REQ-029 Power-up register initial values SHALL equal the reset values.

Verification
REQ-030 N=10, DIGITS=4, WRAP=1: rst, then 1234 ce=1 up=1 cycles -> q=1234 decimal digits, ovf never asserted.
REQ-031 Load 9999, ce=1 up=1 -> tc=1 in the load-following cycle; next q=0000; ovf=1 for exactly one cycle.
REQ-032 Load 0000, ce=1 up=0 -> q=9999 and ovf pulses once; load 1000 then one down step -> q=0999.
REQ-033 WRAP=0: load 9998, 3 up steps -> q=9999, 9999, 9999; sat=1 from the cycle after tc; one down step -> q=9998, sat=0.
REQ-034 Load with digit field 0xF (N=10) -> that digit reads 9; load and ce in the same cycle -> q equals the clamped load value.
REQ-035 Count to 0567, then rst=1 together with load=1 and ce=1 -> q=0000, ovf=0, sat=0 next cycle.
